// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage: field extraction, immediates, 32x32 register file, registered bundle.
// Optional operand forwarding from the writeback port is enabled by defining DECODE_BYPASS_EN.
module decode (
  input  logic        req,
  input  logic        reset,
  input  logic        rs_read,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in_dec,
  input  logic        branch_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] rd_value_in,
  output logic        valid_out,
  output logic [6:0]  alu_op_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  funct7_out,
  output logic        alu_sub_sra_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rs1_value_out,
  output logic [31:0] rs2_value_out,
  output logic [31:0] imm_value_out,
  output logic [31:0] pc_out_dec,
  output logic        branch_out,
  output logic [3:0]  branch_op_out,
  output logic        branch_pc_src_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [31:0] r_regs [32];

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic        w_valid;
  logic        w_sub_sra;
  logic        w_rd_write;
  logic        w_branch;
  logic [3:0]  w_branch_op;
  logic        w_pc_src;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_value;
  logic [31:0] w_rs2_value;
  logic        w_wb_en;

  assign w_opcode  = instr_in[6:0];
  assign w_rd      = instr_in[11:7];
  assign w_funct3  = instr_in[14:12];
  assign w_rs1_idx = instr_in[19:15];
  assign w_rs2_idx = instr_in[24:20];
  assign w_funct7  = instr_in[31:25];
  assign w_wb_en   = rd_write_in && (rd_in != 5'd0);

  always_comb begin
    w_valid     = 1'b0;
    w_sub_sra   = 1'b0;
    w_rd_write  = 1'b0;
    w_branch    = 1'b0;
    w_branch_op = 4'b0000;
    w_pc_src    = 1'b0;
    w_imm       = 32'd0;
    case (w_opcode)
      OPC_OP: begin
        w_valid    = 1'b1;
        w_sub_sra  = instr_in[30];
        w_rd_write = (w_rd != 5'd0);
      end
      OPC_OP_IMM: begin
        w_valid    = 1'b1;
        w_sub_sra  = (w_funct3 == 3'b101) ? instr_in[30] : 1'b0;
        w_rd_write = (w_rd != 5'd0);
        w_imm      = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      OPC_LOAD: begin
        w_valid    = 1'b1;
        w_rd_write = (w_rd != 5'd0);
        w_imm      = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      OPC_STORE: begin
        w_valid = 1'b1;
        w_imm   = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end
      OPC_LUI, OPC_AUIPC: begin
        w_valid    = 1'b1;
        w_rd_write = (w_rd != 5'd0);
        w_imm      = {instr_in[31:12], 12'd0};
      end
      OPC_JAL: begin
        w_valid     = 1'b1;
        w_rd_write  = (w_rd != 5'd0);
        w_branch    = 1'b1;
        w_branch_op = 4'b1111;
        w_imm       = {{12{instr_in[31]}}, instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_valid     = 1'b1;
        w_rd_write  = (w_rd != 5'd0);
        w_branch    = 1'b1;
        w_branch_op = 4'b1111;
        w_pc_src    = 1'b1;
        w_imm       = {{20{instr_in[31]}}, instr_in[31:20]};
      end
      OPC_BRANCH: begin
        w_valid     = 1'b1;
        w_branch    = 1'b1;
        w_branch_op = {1'b0, w_funct3};
        w_imm       = {{20{instr_in[31]}}, instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
      end
      default: begin
        w_valid = 1'b0;
      end
    endcase
  end

  // Source reads see the pre-edge register contents unless forwarding is built in.
  always_comb begin
    w_rs1_value = (w_rs1_idx == 5'd0) ? 32'd0 : r_regs[w_rs1_idx];
    w_rs2_value = (w_rs2_idx == 5'd0) ? 32'd0 : r_regs[w_rs2_idx];
`ifdef DECODE_BYPASS_EN
    if (w_wb_en && (rd_in == w_rs1_idx)) w_rs1_value = rd_value_in;
    if (w_wb_en && (rd_in == w_rs2_idx)) w_rs2_value = rd_value_in;
`else
    w_rs1_value = w_rs1_value;
    w_rs2_value = w_rs2_value;
`endif
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_wb_en) begin
      r_regs[rd_in] <= rd_value_in;
    end
  end

  // Flush outranks decode; a flush only kills the control bits that cause side effects.
  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      valid_out         <= 1'b0;
      alu_op_out        <= 7'd0;
      funct3_out        <= 3'd0;
      funct7_out        <= 7'd0;
      alu_sub_sra_out   <= 1'b0;
      rd_out            <= 5'd0;
      rd_write_out      <= 1'b0;
      rs1_value_out     <= 32'd0;
      rs2_value_out     <= 32'd0;
      imm_value_out     <= 32'd0;
      pc_out_dec        <= 32'd0;
      branch_out        <= 1'b0;
      branch_op_out     <= 4'd0;
      branch_pc_src_out <= 1'b0;
    end else if (branch_in) begin
      valid_out    <= 1'b0;
      rd_write_out <= 1'b0;
      branch_out   <= 1'b0;
    end else if (rs_read) begin
      valid_out         <= w_valid;
      alu_op_out        <= w_opcode;
      funct3_out        <= w_funct3;
      funct7_out        <= w_funct7;
      alu_sub_sra_out   <= w_sub_sra;
      rd_out            <= w_rd;
      rd_write_out      <= w_rd_write;
      rs1_value_out     <= w_rs1_value;
      rs2_value_out     <= w_rs2_value;
      imm_value_out     <= w_imm;
      pc_out_dec        <= pc_in_dec;
      branch_out        <= w_branch;
      branch_op_out     <= w_branch_op;
      branch_pc_src_out <= w_pc_src;
    end
  end

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed-vector bench for decode; expectations follow DECODE_BYPASS_EN when defined.
module tb_decode;

  logic        req = 1'b0;
  logic        reset;
  logic        rs_read;
  logic [31:0] instr_in;
  logic [31:0] pc_in_dec;
  logic        branch_in;
  logic [4:0]  rd_in;
  logic        rd_write_in;
  logic [31:0] rd_value_in;
  logic        valid_out;
  logic [6:0]  alu_op_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic        alu_sub_sra_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rs1_value_out;
  logic [31:0] rs2_value_out;
  logic [31:0] imm_value_out;
  logic [31:0] pc_out_dec;
  logic        branch_out;
  logic [3:0]  branch_op_out;
  logic        branch_pc_src_out;

  int vectors = 0;
  int miscompares = 0;

  decode dut (
    .req(req), .reset(reset), .rs_read(rs_read), .instr_in(instr_in),
    .pc_in_dec(pc_in_dec), .branch_in(branch_in), .rd_in(rd_in),
    .rd_write_in(rd_write_in), .rd_value_in(rd_value_in),
    .valid_out(valid_out), .alu_op_out(alu_op_out), .funct3_out(funct3_out),
    .funct7_out(funct7_out), .alu_sub_sra_out(alu_sub_sra_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .rs1_value_out(rs1_value_out),
    .rs2_value_out(rs2_value_out), .imm_value_out(imm_value_out),
    .pc_out_dec(pc_out_dec), .branch_out(branch_out), .branch_op_out(branch_op_out),
    .branch_pc_src_out(branch_pc_src_out)
  );

  always #5 req = ~req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge req);
    #1;
  endtask

  task automatic dec(input logic [31:0] ins, input logic [31:0] pc);
    rs_read = 1'b1; branch_in = 1'b0; instr_in = ins; pc_in_dec = pc;
    step();
  endtask

  initial begin
    reset = 1'b0; rs_read = 1'b0; instr_in = 32'd0; pc_in_dec = 32'd0;
    branch_in = 1'b0; rd_in = 5'd0; rd_write_in = 1'b0; rd_value_in = 32'd0;
    step(); step();
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_pc", pc_out_dec, 32'd0);
    chk("reset_alu_op", {25'd0, alu_op_out}, 32'd0);
    reset = 1'b1;
    step();
    chk("idle_after_reset_valid", {31'd0, valid_out}, 32'd0);

    dec(32'h00108093, 32'h100);
    chk("addi_valid", {31'd0, valid_out}, 32'd1);
    chk("addi_alu_op", {25'd0, alu_op_out}, 32'h13);
    chk("addi_funct3", {29'd0, funct3_out}, 32'd0);
    chk("addi_rd", {27'd0, rd_out}, 32'd1);
    chk("addi_rd_write", {31'd0, rd_write_out}, 32'd1);
    chk("addi_imm", imm_value_out, 32'd1);
    chk("addi_rs1", rs1_value_out, 32'd0);
    chk("addi_pc", pc_out_dec, 32'h100);

    rs_read = 1'b0; instr_in = 32'h00000233; pc_in_dec = 32'h200;
    rd_write_in = 1'b1; rd_in = 5'd1; rd_value_in = 32'd5;
    step();
    rd_write_in = 1'b0;
    chk("stall_hold_valid", {31'd0, valid_out}, 32'd1);
    chk("stall_hold_imm", imm_value_out, 32'd1);
    chk("stall_hold_pc", pc_out_dec, 32'h100);
    chk("stall_hold_rd", {27'd0, rd_out}, 32'd1);

    dec(32'h00108133, 32'h104);
    chk("add_rs1", rs1_value_out, 32'd5);
    chk("add_rs2", rs2_value_out, 32'd5);
    chk("add_sub_sra", {31'd0, alu_sub_sra_out}, 32'd0);
    chk("add_imm", imm_value_out, 32'd0);
    chk("add_rd", {27'd0, rd_out}, 32'd2);

    dec(32'h40208133, 32'h108);
    chk("sub_sub_sra", {31'd0, alu_sub_sra_out}, 32'd1);
    chk("sub_funct7", {25'd0, funct7_out}, 32'h20);
    chk("sub_rs2", rs2_value_out, 32'd0);

    dec(32'h00000463, 32'h10c);
    chk("beq_branch", {31'd0, branch_out}, 32'd1);
    chk("beq_op", {28'd0, branch_op_out}, 32'd0);
    chk("beq_imm", imm_value_out, 32'd8);
    chk("beq_rd_write", {31'd0, rd_write_out}, 32'd0);
    chk("beq_pc_src", {31'd0, branch_pc_src_out}, 32'd0);

    dec(32'h00101463, 32'h110);
    chk("bne_op", {28'd0, branch_op_out}, 32'd1);
    chk("bne_rs2", rs2_value_out, 32'd5);

    dec(32'h000080e7, 32'h114);
    chk("jalr_branch", {31'd0, branch_out}, 32'd1);
    chk("jalr_op", {28'd0, branch_op_out}, 32'hf);
    chk("jalr_pc_src", {31'd0, branch_pc_src_out}, 32'd1);
    chk("jalr_rs1", rs1_value_out, 32'd5);
    chk("jalr_rd_write", {31'd0, rd_write_out}, 32'd1);

    dec(32'h010000ef, 32'h118);
    chk("jal_imm", imm_value_out, 32'd16);
    chk("jal_op", {28'd0, branch_op_out}, 32'hf);
    chk("jal_pc_src", {31'd0, branch_pc_src_out}, 32'd0);

    dec(32'hfff00093, 32'h11c);
    chk("addi_neg_imm", imm_value_out, 32'hffffffff);
    chk("addi_branch", {31'd0, branch_out}, 32'd0);

    dec(32'h123452b7, 32'h120);
    chk("lui_imm", imm_value_out, 32'h12345000);
    chk("lui_rd", {27'd0, rd_out}, 32'd5);
    chk("lui_rd_write", {31'd0, rd_write_out}, 32'd1);

    dec(32'hfe112e23, 32'h124);
    chk("sw_imm", imm_value_out, 32'hfffffffc);
    chk("sw_rd_write", {31'd0, rd_write_out}, 32'd0);
    chk("sw_valid", {31'd0, valid_out}, 32'd1);
    chk("sw_rs2", rs2_value_out, 32'd5);

    dec(32'h4010d093, 32'h128);
    chk("srai_sub_sra", {31'd0, alu_sub_sra_out}, 32'd1);
    chk("srai_imm", imm_value_out, 32'h401);
    dec(32'h40000093, 32'h12c);
    chk("addi_bit30_sub_sra", {31'd0, alu_sub_sra_out}, 32'd0);

    dec(32'h0000000f, 32'h130);
    chk("fence_valid", {31'd0, valid_out}, 32'd0);
    chk("fence_rd_write", {31'd0, rd_write_out}, 32'd0);
    chk("fence_branch", {31'd0, branch_out}, 32'd0);

    dec(32'h010000ef, 32'h134);
    rs_read = 1'b1; branch_in = 1'b1; instr_in = 32'h00108093;
    step();
    branch_in = 1'b0; rs_read = 1'b0;
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_rd_write", {31'd0, rd_write_out}, 32'd0);
    chk("flush_branch", {31'd0, branch_out}, 32'd0);
    branch_in = 1'b1;
    step();
    branch_in = 1'b0;
    chk("flush_stalled_valid", {31'd0, valid_out}, 32'd0);

    rs_read = 1'b1; instr_in = 32'h00018233; pc_in_dec = 32'h140;
    rd_write_in = 1'b1; rd_in = 5'd3; rd_value_in = 32'h77;
    step();
    rd_write_in = 1'b0;
`ifdef DECODE_BYPASS_EN
    chk("same_edge_x3", rs1_value_out, 32'h77);
`else
    chk("same_edge_x3", rs1_value_out, 32'h0);
`endif
    dec(32'h00018233, 32'h144);
    chk("later_x3", rs1_value_out, 32'h77);

    rs_read = 1'b1; instr_in = 32'h00000233;
    rd_write_in = 1'b1; rd_in = 5'd0; rd_value_in = 32'hdead;
    step();
    rd_write_in = 1'b0;
    chk("x0_write_same", rs1_value_out, 32'd0);
    dec(32'h00000233, 32'h148);
    chk("x0_write_after", rs2_value_out, 32'd0);

    dec(32'h00108093, 32'h14c);
    rs_read = 1'b0;
    @(negedge req);
    reset = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, valid_out}, 32'd0);
    chk("async_reset_pc", pc_out_dec, 32'd0);
    #3;
    reset = 1'b1;
    step();
    chk("post_reset_stall_valid", {31'd0, valid_out}, 32'd0);
    dec(32'h00018233, 32'h150);
    chk("regs_cleared_x3", rs1_value_out, 32'd0);
    chk("post_reset_valid", {31'd0, valid_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
